// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the ALU1 pipeline sequencing controller.
package rv_ctrl_pkg;

   typedef enum logic [1:0] {
      CTRL_IDLE     = 2'd0,
      CTRL_DRAIN    = 2'd1,
      CTRL_REDIRECT = 2'd2
   } ctrl_state_t;

   localparam int unsigned CTRL_DRAIN_W = 4;

endpackage

// File: rtl/rv_perf_cnt.sv
// Enable-increment wrapping counter; only compiled when RV_PIPE_PERF_CNT_EN is defined.
`ifdef RV_PIPE_PERF_CNT_EN
module rv_perf_cnt #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_cnt
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_en) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign o_cnt = cnt_q;

endmodule
`endif

// File: rtl/rv_pipe_ctrl.sv
// ALU1 flush/redirect/trap-drain sequencer with load-use stall generation.
// Optional perf counters are enabled by defining RV_PIPE_PERF_CNT_EN.
module rv_pipe_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int unsigned IADDR_SPACE_BITS = 32,
   parameter int unsigned DRAIN_TIMEOUT    = 15,
   parameter int unsigned CNT_WIDTH        = 32
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_alu_valid,
   input  logic                        i_inst_branch,
   input  logic                        i_branch_taken,
   input  logic                        i_branch_pred,
   input  logic                        i_inst_jal_jalr,
   input  logic                        i_to_trap,
   input  logic [IADDR_SPACE_BITS-1:0] i_pc_target,
   input  logic [IADDR_SPACE_BITS-1:0] i_pc_next,
   input  logic [IADDR_SPACE_BITS-1:0] i_trap_vector,
   input  logic                        i_store_pending,
   input  logic                        i_alu_load,
   input  logic [4:0]                  i_alu_rd,
   input  logic [4:0]                  i_dec_rs1,
   input  logic [4:0]                  i_dec_rs2,
   input  logic                        i_fetch_ready,
   output logic                        o_flush,
   output logic                        o_stall,
   output logic                        o_redirect,
   output logic [IADDR_SPACE_BITS-1:0] o_redirect_pc,
   output logic                        o_trap_enter,
   output logic                        o_busy,
   output logic [CNT_WIDTH-1:0]        o_branch_cnt,
   output logic [CNT_WIDTH-1:0]        o_mispred_cnt
);

   ctrl_state_t                 state_q, state_d;
   logic [CTRL_DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
   logic [IADDR_SPACE_BITS-1:0] redirect_pc_q, redirect_pc_d;
   logic                        trap_det, mis_det, load_use, drain_done;

   always_comb begin
      trap_det = i_alu_valid & i_to_trap;
      mis_det  = i_alu_valid &
                 ((i_inst_branch & (i_branch_taken != i_branch_pred)) | i_inst_jal_jalr);
      load_use = i_alu_valid & i_alu_load & (i_alu_rd != 5'd0) &
                 ((i_alu_rd == i_dec_rs1) | (i_alu_rd == i_dec_rs2));
   end

   always_comb begin
      state_d       = state_q;
      drain_cnt_d   = drain_cnt_q;
      redirect_pc_d = redirect_pc_q;
      drain_done    = 1'b0;
      o_flush       = 1'b0;
      o_stall       = 1'b0;
      o_redirect    = 1'b0;
      o_trap_enter  = 1'b0;
      unique case (state_q)
         CTRL_IDLE: begin
            drain_cnt_d = '0;
            if (trap_det) begin
               o_flush = 1'b1;
               state_d = CTRL_DRAIN;
            end else if (mis_det) begin
               o_flush       = 1'b1;
               redirect_pc_d = (i_inst_jal_jalr | i_branch_taken) ? i_pc_target : i_pc_next;
               state_d       = CTRL_REDIRECT;
            end else begin
               o_stall = load_use;
            end
         end
         CTRL_DRAIN: begin
            o_flush     = 1'b1;
            o_stall     = 1'b1;
            drain_cnt_d = drain_cnt_q + 1'b1;
            // Count includes the current cycle, so a timeout of N gives exactly N drain cycles.
            drain_done  = !i_store_pending |
                          (drain_cnt_d == CTRL_DRAIN_W'(DRAIN_TIMEOUT));
            if (drain_done) begin
               o_trap_enter  = 1'b1;
               redirect_pc_d = i_trap_vector;
               state_d       = CTRL_REDIRECT;
            end
         end
         CTRL_REDIRECT: begin
            o_flush    = 1'b1;
            o_redirect = 1'b1;
            if (i_fetch_ready) state_d = CTRL_IDLE;
         end
         default: state_d = CTRL_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= CTRL_IDLE;
         drain_cnt_q   <= '0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         drain_cnt_q   <= drain_cnt_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign o_redirect_pc = redirect_pc_q;
   assign o_busy        = (state_q != CTRL_IDLE);

`ifdef RV_PIPE_PERF_CNT_EN
   logic branch_inc, mispred_inc;

   assign branch_inc  = (state_q == CTRL_IDLE) & i_alu_valid & i_inst_branch;
   assign mispred_inc = (state_q == CTRL_IDLE) & ~trap_det & mis_det;

   rv_perf_cnt #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (branch_inc),
      .o_cnt   (o_branch_cnt)
   );

   rv_perf_cnt #(.WIDTH(CNT_WIDTH)) u_mispred_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (mispred_inc),
      .o_cnt   (o_mispred_cnt)
   );
`else
   assign o_branch_cnt  = '0;
   assign o_mispred_cnt = '0;
`endif

endmodule

// File: doc/rv_pipe_ctrl.md
Name: rv_pipe_ctrl

Overview:
Pipeline sequencing controller for the ALU1 (execute) stage. It resolves control-flow outcomes leaving ALU1 (branch mispredicts, jal/jalr/mret, traps) and sequences the flush/redirect to fetch through a handshake. Before trap entry it drains pending stores, and it generates load-use stalls for decode. It drives the i_flush input of the decode and ALU1 stages and the redirect port of the fetch unit.

Parameters:
IADDR_SPACE_BITS, 32, width of all PC/target buses
DRAIN_TIMEOUT, 15, max cycles to wait for store drain before forcing trap entry (4-bit counter, 1..15)
CNT_WIDTH, 32, width of the performance counters (optional feature)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_alu_valid  in  1  ALU1 holds a live instruction this cycle
i_inst_branch  in  1  ALU1 instruction is a conditional branch
i_branch_taken  in  1  branch comparison result for ALU1 instruction
i_branch_pred  in  1  fetch predicted taken
i_inst_jal_jalr  in  1  jal/jalr/mret in ALU1
i_to_trap  in  1  ALU1 instruction raises a trap
i_pc_target  in  IADDR_SPACE_BITS  computed target from ALU1
i_pc_next  in  IADDR_SPACE_BITS  sequential PC of ALU1 instruction
i_trap_vector  in  IADDR_SPACE_BITS  trap handler address (from CSR unit)
i_store_pending  in  1  LSU has outstanding stores
i_alu_load  in  1  ALU1 instruction is a load (res_src = memory)
i_alu_rd  in  5  ALU1 destination register
i_dec_rs1  in  5  decode source 1
i_dec_rs2  in  5  decode source 2
i_fetch_ready  in  1  fetch accepts redirect this cycle
o_flush  out  1  flush decode and ALU1 stage registers
o_stall  out  1  hold fetch and decode
o_redirect  out  1  redirect request to fetch
o_redirect_pc  out  IADDR_SPACE_BITS  redirect address
o_trap_enter  out  1  one-cycle pulse to CSR unit: commit trap entry
o_busy  out  1  FSM not in IDLE
o_branch_cnt  out  CNT_WIDTH  retired branches (optional feature)
o_mispred_cnt  out  CNT_WIDTH  redirects caused by mispredict/jump (optional feature)

Behaviour:
- Reset (sync, active-high): state IDLE; drain counter 0; redirect_pc register 0; all outputs 0; counters 0. Reset mid-operation abandons any redirect or drain immediately.
- Detection in IDLE only, gated by i_alu_valid:
  - trap_det = i_to_trap.
  - mis_det = (i_inst_branch & (i_branch_taken != i_branch_pred)) | i_inst_jal_jalr.
  - Trap has priority over mis_det.
- States:
  - IDLE:
    - trap_det: o_flush=1 (combinational, same cycle); next state DRAIN.
    - else mis_det: o_flush=1 in the same cycle; latch redirect_pc = (i_inst_jal_jalr | i_branch_taken) ? i_pc_target : i_pc_next; next state REDIRECT.
  - DRAIN: o_flush=1, o_stall=1. Counter increments each cycle. Exit when !i_store_pending or counter == DRAIN_TIMEOUT, then latch redirect_pc = i_trap_vector, pulse o_trap_enter for exactly 1 cycle on the exit cycle, and go to REDIRECT.
  - REDIRECT: o_redirect=1, o_flush=1, o_stall=0, o_redirect_pc stable. When i_fetch_ready=1, go to IDLE the next cycle (handshake completes the cycle both are high). o_redirect is never dropped before acceptance.
- Wrong-path ALU1 instructions in non-IDLE states are ignored: no detection, no stall.
- Load-use stall, IDLE only: o_stall = i_alu_valid & i_alu_load & (i_alu_rd != 0) & (i_alu_rd == i_dec_rs1 | i_alu_rd == i_dec_rs2). Lasts 1 cycle per occurrence. If flush is asserted in the same cycle, stall is forced to 0.
- o_busy = (state != IDLE).
- Latency: flush is 0 cycles after detection; redirect is presented 1 cycle after a mispredict, and 2 or more cycles after a trap.
- o_redirect_pc holds its last value when o_redirect=0.

Optional Feature:
- RV_PIPE_PERF_CNT_EN defined:
  - o_branch_cnt increments on each IDLE cycle with i_alu_valid & i_inst_branch.
  - o_mispred_cnt increments on each mis_det that enters REDIRECT.
  - Both counters wrap at 2^CNT_WIDTH and are cleared by reset.
- Undefined: both ports tied to 0 and no counter flops are present.

Decomposition:
- Shared package rv_ctrl_pkg:
  - ctrl_state_t enum {CTRL_IDLE, CTRL_DRAIN, CTRL_REDIRECT}, encoded in 2 bits.
  - Constant CTRL_DRAIN_W = 4.
- Sub-module rv_perf_cnt: parameterised enable-increment wrapping counter, instantiated twice under the macro.

Test Plan:
- Mispredict: branch, pred=0, taken=1, pc_target=0x100 → o_flush=1 same cycle; o_redirect=1 with pc 0x100 next cycle; i_fetch_ready delayed 3 cycles → redirect held 4 cycles, then IDLE.
- Wrong-path masking: correct not-taken with pred=1, pc_next=0x24 → redirect to 0x24. A mispredicting branch in ALU1 during REDIRECT is ignored, and o_mispred_cnt increments by exactly 1.
- Trap drain: i_to_trap with i_store_pending high 3 cycles, trap_vector=0x80 → 3 DRAIN cycles with o_stall=1, one o_trap_enter pulse, then redirect to 0x80.
- Trap precedence and timeout: i_to_trap & i_inst_jal_jalr together, store_pending stuck high → after 15 DRAIN cycles, forced trap entry; redirect to the trap vector, not the jump target.
- Load-use: load rd=5, dec_rs2=5 → o_stall one cycle. rd=0 → no stall. Same hazard coincident with a mispredict → stall=0, flush=1.
- Reset in REDIRECT: i_reset=1 → next cycle all outputs 0, state IDLE, counters 0.
